// File: rtl/mod_a_feeder.sv
// Circular FIFO of operand bit pairs feeding mod_a's in1/in2 under valid/ready handshakes.
// Optional rejected-write counter enabled by defining MOD_A_FEEDER_DROP_CNT_EN.
module mod_a_feeder #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  logic                       wr_in1,
    input  logic                       wr_in2,
    output logic                       wr_ready,
    output logic                       in1,
    output logic                       in2,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     count
`ifdef MOD_A_FEEDER_DROP_CNT_EN
    ,
    output logic [7:0]                 drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_mem1;
    logic [DEPTH-1:0] r_mem2;
    logic             r_rd_valid;
    logic             r_wr_ready;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic [CW-1:0]    w_count_nxt;

    assign w_wr_fire = wr_valid && r_wr_ready;
    assign w_rd_fire = r_rd_valid && rd_ready;

    // Next occupancy: a simultaneous read and write leaves the level unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_fire, w_rd_fire})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy, storage and the flags derived from the next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_mem1     <= {DEPTH{1'b0}};
            r_mem2     <= {DEPTH{1'b0}};
            r_rd_valid <= 1'b0;
            r_wr_ready <= 1'b1;
        end else begin
            if (w_wr_fire) begin
                r_mem1[r_wr_ptr] <= wr_in1;
                r_mem2[r_wr_ptr] <= wr_in2;
                r_wr_ptr         <= r_wr_ptr + AW'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_rd_valid <= (w_count_nxt != {CW{1'b0}});
            r_wr_ready <= (w_count_nxt != FULL_LVL);
        end
    end

    // Head entry is masked to zero whenever nothing valid is presented.
    assign in1      = r_rd_valid & r_mem1[r_rd_ptr];
    assign in2      = r_rd_valid & r_mem2[r_rd_ptr];
    assign rd_valid = r_rd_valid;
    assign wr_ready = r_wr_ready;
    assign count    = r_count;

`ifdef MOD_A_FEEDER_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of writes offered while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'd0;
        end else if (wr_valid && !r_wr_ready && (r_drop_cnt != 8'd255)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_mod_a_feeder.sv
// Directed self-checking bench for mod_a_feeder (DEPTH = 4).
module tb_mod_a_feeder;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_in1;
    logic       wr_in2;
    logic       wr_ready;
    logic       in1;
    logic       in2;
    logic       rd_valid;
    logic       rd_ready;
    logic [2:0] count;
`ifdef MOD_A_FEEDER_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_checks;
    int n_fail;

    mod_a_feeder #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_in1   (wr_in1),
        .wr_in2   (wr_in2),
        .wr_ready (wr_ready),
        .in1      (in1),
        .in2      (in2),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .count    (count)
`ifdef MOD_A_FEEDER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic v, input logic [1:0] p);
        wr_valid = v;
        wr_in1   = p[1];
        wr_in2   = p[0];
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rd_valid !== 1'b0 || wr_ready !== 1'b1 || count !== 3'd0 || {in1, in2} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state: rd_valid=%b wr_ready=%b count=%0d in=%b%b required 0 1 0 00",
                     rd_valid, wr_ready, count, in1, in2);
        end
        #20;
        rst_n = 1'b1;
    endtask

    task automatic test_single_pair();
        set_wr(1'b1, 2'b10);
        rd_ready = 1'b0;
        step();
        set_wr(1'b0, 2'b00);
        n_checks++;
        if (rd_valid !== 1'b1 || {in1, in2} !== 2'b10 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL single_write: rd_valid=%b in=%b%b count=%0d required 1 10 1",
                     rd_valid, in1, in2, count);
        end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || {in1, in2} !== 2'b00 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL single_read: rd_valid=%b in=%b%b count=%0d required 0 00 0",
                     rd_valid, in1, in2, count);
        end
    endtask

    task automatic test_fill_order();
        logic [1:0] pat [4];
        pat = '{2'b00, 2'b01, 2'b10, 2'b11};
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, pat[i]);
            step();
        end
        n_checks++;
        if (count !== 3'd4 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: count=%0d wr_ready=%b required 4 0", count, wr_ready);
        end
        set_wr(1'b1, 2'b11);
        step();
        set_wr(1'b0, 2'b00);
        n_checks++;
        if (count !== 3'd4 || {in1, in2} !== 2'b00) begin
            n_fail++;
            $display("FAIL fifth_ignored: count=%0d head=%b%b required 4 00", count, in1, in2);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rd_valid !== 1'b1 || {in1, in2} !== pat[i]) begin
                n_fail++;
                $display("FAIL drain_order[%0d]: rd_valid=%b in=%b%b required 1 %b",
                         i, rd_valid, in1, in2, pat[i]);
            end
            rd_ready = 1'b1;
            step();
        end
        rd_ready = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_empty: rd_valid=%b count=%0d required 0 0", rd_valid, count);
        end
    endtask

    task automatic test_full_rw();
        logic [1:0] pat [4];
        pat = '{2'b11, 2'b01, 2'b10, 2'b00};
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, pat[i]);
            step();
        end
        set_wr(1'b1, 2'b11);
        rd_ready = 1'b1;
        step();
        set_wr(1'b0, 2'b00);
        rd_ready = 1'b0;
        n_checks++;
        if (count !== 3'd3 || wr_ready !== 1'b1 || {in1, in2} !== 2'b01) begin
            n_fail++;
            $display("FAIL full_rw: count=%0d wr_ready=%b head=%b%b required 3 1 01",
                     count, wr_ready, in1, in2);
        end
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (rd_valid !== 1'b1 || {in1, in2} !== pat[i]) begin
                n_fail++;
                $display("FAIL full_rw_drain[%0d]: rd_valid=%b in=%b%b required 1 %b",
                         i, rd_valid, in1, in2, pat[i]);
            end
            rd_ready = 1'b1;
            step();
        end
        rd_ready = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL full_rw_not_stored: rd_valid=%b count=%0d required 0 0", rd_valid, count);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] pat [10];
        pat = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10};
        rd_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_wr(1'b1, pat[k]);
            step();
            n_checks++;
            if (rd_valid !== 1'b1 || {in1, in2} !== pat[k] || count !== 3'd1) begin
                n_fail++;
                $display("FAIL wrap[%0d]: rd_valid=%b in=%b%b count=%0d required 1 %b 1",
                         k, rd_valid, in1, in2, count, pat[k]);
            end
        end
        set_wr(1'b0, 2'b00);
        step();
        rd_ready = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_end: rd_valid=%b count=%0d required 0 0", rd_valid, count);
        end
    endtask

    task automatic test_reset_mid();
        rd_ready = 1'b0;
        set_wr(1'b1, 2'b11);
        step();
        step();
        set_wr(1'b1, 2'b10);
        step();
        set_wr(1'b0, 2'b00);
        n_checks++;
        if (count !== 3'd3) begin
            n_fail++;
            $display("FAIL mid_pre_count: count=%0d required 3", count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rd_valid !== 1'b0 || {in1, in2} !== 2'b00 || count !== 3'd0 || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: rd_valid=%b in=%b%b count=%0d wr_ready=%b required 0 00 0 1",
                     rd_valid, in1, in2, count, wr_ready);
        end
        #1;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (rd_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_after_release: rd_valid=%b count=%0d required 0 0", rd_valid, count);
        end
        set_wr(1'b1, 2'b01);
        step();
        set_wr(1'b0, 2'b00);
        n_checks++;
        if ({in1, in2} !== 2'b01 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL mid_new_data: head=%b%b count=%0d required 01 1", in1, in2, count);
        end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || {in1, in2} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_old_data: rd_valid=%b in=%b%b required 0 00", rd_valid, in1, in2);
        end
    endtask

`ifdef MOD_A_FEEDER_DROP_CNT_EN
    task automatic test_drop_cnt();
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, 2'b11);
            step();
        end
        n_checks++;
        if (drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL drop_start: drop_cnt=%0d required 0", drop_cnt);
        end
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 9) begin
                n_checks++;
                if (drop_cnt !== 8'd10) begin
                    n_fail++;
                    $display("FAIL drop_partial: drop_cnt=%0d required 10", drop_cnt);
                end
            end
        end
        set_wr(1'b0, 2'b00);
        n_checks++;
        if (drop_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL drop_saturate: drop_cnt=%0d required 255", drop_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL drop_reset: drop_cnt=%0d required 0", drop_cnt);
        end
        #1;
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        rd_ready = 1'b0;
        set_wr(1'b0, 2'b00);
        test_reset();
        test_single_pair();
        test_fill_order();
        test_full_rw();
        test_wrap();
        test_reset_mid();
`ifdef MOD_A_FEEDER_DROP_CNT_EN
        test_drop_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
